// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Sequencer for the pipeline registers of a 5-stage in-order core (IF/ID,
// ID/EX, EX/MEM, MEM/WB) and the PC. It decides, every cycle, which registers
// load (en), which are squashed to a bubble (clr), and tracks a small FSM for
// data-memory waits and the multi-cycle fetch bubble after a taken branch.
// A register with en=0 holds its value; clr has priority over en.
//
// Parameters
//   REDIRECT_CYC  extra IF/ID bubble cycles after a taken branch (0..15)
//   CNT_W         width of the saturating performance counters
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_rs1, id_rs2             source registers of the instruction in ID
//   id_use_rs1, id_use_rs2     ID instruction actually reads rs1 / rs2
//   ex_rd, ex_mem_read         destination and load flag of the EX instruction
//   ex_br_taken                EX resolved a taken branch / jump
//   mem_req, mem_ack           MEM-stage data access and its completion
//   cnt_clr                    synchronous clear of both perf counters
//   pc_en                      PC update enable
//   <stage>_en / <stage>_clr   load enable / synchronous clear per register
//   state_o                    FSM state: 0 RUN, 1 MEM_WAIT, 2 REDIRECT
//   stall_cnt                  cycles with pc_en=0 (saturating)
//   flush_cnt                  taken-branch flush events (saturating)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned REDIRECT_CYC = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             exmem_clr,
    output logic             memwb_en,
    output logic             memwb_clr,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    // Reload value for the redirect bubble counter; zero disables REDIRECT.
    localparam logic [3:0] RC_RELOAD    = 4'(REDIRECT_CYC);
    localparam bit         HAS_REDIRECT = (REDIRECT_CYC != 0);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] rc;
    logic [3:0] rc_nxt;
    logic       flush_evt;
    logic       load_use;
    logic       mem_stall;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (ex_rd == id_rs1)) |
                       (id_use_rs2 & (ex_rd == id_rs2)));

    assign mem_stall = mem_req & ~mem_ack;

    assign state_o = state;

    // -------------------------------------------------------------------------
    // Decode: outputs and next state are purely combinational from state and
    // inputs, so during reset they follow the RUN decode.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_en   = 1'b1;
        idex_clr  = 1'b0;
        exmem_en  = 1'b1;
        exmem_clr = 1'b0;
        memwb_en  = 1'b1;
        memwb_clr = 1'b0;
        state_nxt = state;
        rc_nxt    = rc;
        flush_evt = 1'b0;

        if (mem_stall) begin
            // Freeze: the whole pipe holds, nothing is squashed, rc holds.
            // A branch or load-use seen now is re-evaluated once the access
            // completes, because EX and ID are held with it.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            if (state == S_RUN) begin
                state_nxt = S_MEM_WAIT;
            end
        end else begin
            case (state)
                S_REDIRECT: begin
                    // Fetch is still returning wrong-path words: keep
                    // squashing IF/ID; load-use cannot matter on a bubble.
                    ifid_clr = 1'b1;
                    if (ex_br_taken) begin
                        idex_clr  = 1'b1;
                        flush_evt = 1'b1;
                        rc_nxt    = RC_RELOAD;
                    end else if (rc <= 4'd1) begin
                        rc_nxt    = 4'd0;
                        state_nxt = S_RUN;
                    end else begin
                        rc_nxt = rc - 4'd1;
                    end
                end

                // RUN, the ack cycle of MEM_WAIT, and the unused encoding all
                // share the normal decode and RUN's next-state rule.
                default: begin
                    state_nxt = S_RUN;
                    if (ex_br_taken) begin
                        ifid_clr  = 1'b1;
                        idex_clr  = 1'b1;
                        flush_evt = 1'b1;
                        if (HAS_REDIRECT) begin
                            state_nxt = S_REDIRECT;
                            rc_nxt    = RC_RELOAD;
                        end
                    end else if (load_use) begin
                        // One-cycle bubble: hold PC and IF/ID, squash ID/EX,
                        // let the load move on into MEM.
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_clr = 1'b1;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            rc    <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state <= state_nxt;
            rc    <= rc_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters: saturate at all-ones, clear wins over increment.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
